// File: rtl/vm_pkg.sv
`default_nettype none
//============================================================================
// Module   : vm_pkg
// Brief    : Shared constants and types for the vending-machine config master:
//            price register map, error codes, FSM encodings, coin codes.
// Revision : 1.0 - initial release
//============================================================================
package vm_pkg;

  // Price register map of the vending machine slave
  localparam logic [15:0] ADDR_TEA    = 16'h0000;
  localparam logic [15:0] ADDR_COFFEE = 16'h0004;
  localparam logic [15:0] ADDR_MILK   = 16'h0008;

  // err_code encodings
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Coin codes accepted by the machine
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  // Shared FSM encoding; the transfer engine uses IDLE/REQ/GAP, the
  // sequencer uses IDLE/REQ (transfer in flight)/DONE/ERR.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } vm_state_t;

  // Map a sequence index (0-2 writes, 3-5 reads) to its price register
  function automatic logic [1:0] reg_of(input logic [2:0] idx);
    case (idx)
      3'd1, 3'd4: reg_of = 2'd1;
      3'd2, 3'd5: reg_of = 2'd2;
      default:    reg_of = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_bus_xfer.sv
`default_nettype none
//============================================================================
// Module   : vm_bus_xfer
// Brief    : Single pvalid/pready transfer engine. Raises pvalid on go, waits
//            for pready, then waits for pready to fall before accepting the
//            next go. Aborts with tmo if either wait exceeds TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
//============================================================================
module vm_bus_xfer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        go,
  input  logic        go_wr,
  input  logic [15:0] go_addr,
  input  logic [15:0] go_wdata,
  input  logic        abort,
  input  logic        pready,
  output logic        pvalid,
  output logic        wr_rd,
  output logic [15:0] paddr,
  output logic [15:0] pwdata,
  output logic        ack,
  output logic        fin,
  output logic        tmo
);
  import vm_pkg::*;

  localparam int             CW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  c_cnt_last = CW'(TIMEOUT_CYCLES - 1);

  vm_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_pvalid, w_pvalid_nxt;
  logic          r_wr, w_wr_nxt;
  logic [15:0]   r_addr, w_addr_nxt;
  logic [15:0]   r_wdata, w_wdata_nxt;
  logic          w_load;

  // Handshake events seen on the current edge; ack wins over timeout
  assign ack = (r_state == S_REQ) && pready;
  assign fin = (r_state == S_GAP) && !pready;
  assign tmo = ((r_state == S_REQ) || (r_state == S_GAP)) && !ack && !fin &&
               (r_cnt == c_cnt_last);

  assign pvalid = r_pvalid;
  assign wr_rd  = r_wr;
  assign paddr  = r_addr;
  assign pwdata = r_wdata;

  // Next-state and next bus values; a go in GAP chains straight into REQ
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_pvalid_nxt = r_pvalid;
    w_wr_nxt     = r_wr;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_load    = go;
      end
      S_REQ: begin
        if (ack) begin
          w_state_nxt  = S_GAP;
          w_cnt_nxt    = '0;
          w_pvalid_nxt = 1'b0;
        end else if (tmo) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_pvalid_nxt = 1'b0;
        end
      end
      S_GAP: begin
        if (fin) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_load      = go;
        end else if (tmo) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = '0;
        w_pvalid_nxt = 1'b0;
      end
    endcase
    if (w_load) begin
      w_state_nxt  = S_REQ;
      w_cnt_nxt    = '0;
      w_pvalid_nxt = 1'b1;
      w_wr_nxt     = go_wr;
      w_addr_nxt   = go_addr;
      w_wdata_nxt  = go_wr ? go_wdata : 16'h0000;
    end
    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_pvalid_nxt = 1'b0;
    end
  end

  // Engine state, timeout counter and registered bus outputs
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pvalid <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pvalid <= w_pvalid_nxt;
      r_wr     <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vm_cfg_master.sv
`default_nettype none
//============================================================================
// Module   : vm_cfg_master
// Brief    : Programs tea/coffee/milk prices into the vending machine over the
//            pvalid/pready bus on a start pulse and reports done or an error.
//            Build option VM_CFG_READBACK_EN adds a read-back of all three
//            registers with a low-byte compare; without it only the three
//            writes are issued.
// Revision : 1.0 - initial release
//============================================================================
module vm_cfg_master #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] ADDR_TEA       = 16'h0000,
  parameter logic [15:0] ADDR_COFFEE    = 16'h0004,
  parameter logic [15:0] ADDR_MILK      = 16'h0008
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        start,
  input  logic [15:0] tea_cost_in,
  input  logic [15:0] coffee_cost_in,
  input  logic [15:0] milk_cost_in,
  output logic        pvalid,
  output logic        wr_rd,
  output logic [15:0] paddr,
  output logic [15:0] pwdata,
  input  logic        pready,
  input  logic [7:0]  prdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [1:0]  err_idx
);
  import vm_pkg::*;

`ifdef VM_CFG_READBACK_EN
  localparam logic [2:0] c_last_idx = 3'd5;
`else
  localparam logic [2:0] c_last_idx = 3'd2;
`endif
  localparam logic [2:0] c_first_read = 3'd3;

  vm_state_t   r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [15:0] r_tea_cost, w_tea_cost_nxt;
  logic [15:0] r_coffee_cost, w_coffee_cost_nxt;
  logic [15:0] r_milk_cost, w_milk_cost_nxt;
  logic        r_err, w_err_nxt;
  logic [1:0]  r_err_code, w_err_code_nxt;
  logic [1:0]  r_err_idx, w_err_idx_nxt;

  logic        w_go, w_abort, w_go_wr;
  logic [2:0]  w_go_idx;
  logic [1:0]  w_go_reg;
  logic [15:0] w_go_addr, w_go_cost, w_go_wdata;
  logic        w_ack, w_fin, w_tmo, w_mismatch;

  // Transfer descriptor for the next go; in IDLE the costs come straight from
  // the inputs because they are captured on the same edge the go is issued
  always_comb begin
    w_go_idx = (r_state == S_IDLE) ? 3'd0 : r_idx + 3'd1;
    w_go_reg = reg_of(w_go_idx);
    w_go_wr  = (w_go_idx < c_first_read);
    case (w_go_reg)
      2'd1: begin
        w_go_addr = ADDR_COFFEE;
        w_go_cost = (r_state == S_IDLE) ? coffee_cost_in : r_coffee_cost;
      end
      2'd2: begin
        w_go_addr = ADDR_MILK;
        w_go_cost = (r_state == S_IDLE) ? milk_cost_in : r_milk_cost;
      end
      default: begin
        w_go_addr = ADDR_TEA;
        w_go_cost = (r_state == S_IDLE) ? tea_cost_in : r_tea_cost;
      end
    endcase
    w_go_wdata = w_go_wr ? w_go_cost : 16'h0000;
  end

`ifdef VM_CFG_READBACK_EN
  logic [7:0] w_cur_lo;

  // Low byte of the price being read back; the slave only returns 8 bits
  always_comb begin
    case (reg_of(r_idx))
      2'd1:    w_cur_lo = r_coffee_cost[7:0];
      2'd2:    w_cur_lo = r_milk_cost[7:0];
      default: w_cur_lo = r_tea_cost[7:0];
    endcase
  end

  assign w_mismatch = w_ack && (r_idx >= c_first_read) && (prdata != w_cur_lo);
`else
  logic w_unused_rb;

  assign w_mismatch  = 1'b0;
  assign w_unused_rb = ^{prdata, w_ack};
`endif

  // Sequencer next-state: index stepping, error capture and engine control
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_tea_cost_nxt    = r_tea_cost;
    w_coffee_cost_nxt = r_coffee_cost;
    w_milk_cost_nxt   = r_milk_cost;
    w_err_nxt         = r_err;
    w_err_code_nxt    = r_err_code;
    w_err_idx_nxt     = r_err_idx;
    w_go              = 1'b0;
    w_abort           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt       = S_REQ;
          w_idx_nxt         = 3'd0;
          w_tea_cost_nxt    = tea_cost_in;
          w_coffee_cost_nxt = coffee_cost_in;
          w_milk_cost_nxt   = milk_cost_in;
          w_err_nxt         = 1'b0;
          w_err_code_nxt    = ERR_NONE;
          w_err_idx_nxt     = 2'd0;
          w_go              = 1'b1;
        end
      end
      S_REQ: begin
        if (w_tmo) begin
          w_state_nxt    = S_ERR;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
          w_err_idx_nxt  = reg_of(r_idx);
        end else if (w_mismatch) begin
          w_state_nxt    = S_ERR;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_MISMATCH;
          w_err_idx_nxt  = reg_of(r_idx);
        end else if (w_fin) begin
          if (r_idx == c_last_idx) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_go      = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        // Engine may still sit in GAP after a mismatch; park it
        w_abort     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state, captured prices and sticky error status
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state       <= S_IDLE;
      r_idx         <= 3'd0;
      r_tea_cost    <= 16'h0000;
      r_coffee_cost <= 16'h0000;
      r_milk_cost   <= 16'h0000;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_err_idx     <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_tea_cost    <= w_tea_cost_nxt;
      r_coffee_cost <= w_coffee_cost_nxt;
      r_milk_cost   <= w_milk_cost_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
      r_err_idx     <= w_err_idx_nxt;
    end
  end

  assign busy     = (r_state == S_REQ);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign err_code = r_err_code;
  assign err_idx  = r_err_idx;

  vm_bus_xfer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_xfer (
    .pclk     (pclk),
    .prst     (prst),
    .go       (w_go),
    .go_wr    (w_go_wr),
    .go_addr  (w_go_addr),
    .go_wdata (w_go_wdata),
    .abort    (w_abort),
    .pready   (pready),
    .pvalid   (pvalid),
    .wr_rd    (wr_rd),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .ack      (w_ack),
    .fin      (w_fin),
    .tmo      (w_tmo)
  );

endmodule
`default_nettype wire

// File: tb/tb_vm_cfg_master.sv
`default_nettype none
//============================================================================
// Module   : tb_vm_cfg_master
// Brief    : Scoreboard bench for vm_cfg_master with a registered slave model
//            (normal / never-ready / stuck-ready / corrupt-tea-readback).
// Revision : 1.0 - initial release
//============================================================================
module tb_vm_cfg_master;

  localparam logic [1:0] K_XFER = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  code;
    logic [1:0]  idx;
  } exp_t;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tea_cost_in = 16'h0;
  logic [15:0] coffee_cost_in = 16'h0;
  logic [15:0] milk_cost_in = 16'h0;
  logic        pvalid, wr_rd, busy, done, err;
  logic [15:0] paddr, pwdata;
  logic [1:0]  err_code, err_idx;
  logic        pready;
  logic [7:0]  prdata;

  int          mode = 0;  // 0 normal, 1 never ready, 2 stuck ready, 3 corrupt tea read
  logic [15:0] mem [0:3];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 pclk = ~pclk;

  vm_cfg_master dut (
    .pclk           (pclk),
    .prst           (prst),
    .start          (start),
    .tea_cost_in    (tea_cost_in),
    .coffee_cost_in (coffee_cost_in),
    .milk_cost_in   (milk_cost_in),
    .pvalid         (pvalid),
    .wr_rd          (wr_rd),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .pready         (pready),
    .prdata         (prdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code),
    .err_idx        (err_idx)
  );

  // Registered slave: pready follows pvalid one cycle late
  always @(posedge pclk or negedge prst) begin
    if (!prst) begin
      pready <= 1'b0;
      prdata <= 8'h00;
    end else begin
      case (mode)
        1:       pready <= 1'b0;
        2:       pready <= 1'b1;
        default: pready <= pvalid;
      endcase
      if (pvalid && wr_rd) mem[paddr[3:2]] <= pwdata;
      if (pvalid && !wr_rd)
        prdata <= mem[paddr[3:2]][7:0] ^ (((mode == 3) && (paddr == 16'h0)) ? 8'h01 : 8'h00);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_x(input logic wr, input logic [15:0] addr, input logic [15:0] data);
    exp_t e;
    e = '0; e.kind = K_XFER; e.wr = wr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e = '0; e.kind = K_DONE;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code, input logic [1:0] idx);
    exp_t e;
    e = '0; e.kind = K_ERR; e.code = code; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [15:0] t, input logic [15:0] c, input logic [15:0] m);
    push_x(1'b1, 16'h0000, t);
    push_x(1'b1, 16'h0004, c);
    push_x(1'b1, 16'h0008, m);
`ifdef VM_CFG_READBACK_EN
    push_x(1'b0, 16'h0000, 16'h0);
    push_x(1'b0, 16'h0004, 16'h0);
    push_x(1'b0, 16'h0008, 16'h0);
`endif
    push_done();
  endtask

  // Pulse start and run until busy drops; poke re-pulses start mid-sequence
  task automatic run(input logic [15:0] t, input logic [15:0] c, input logic [15:0] m,
                     input int poke, output int cyc, output int pv_hi, output logic err0);
    @(negedge pclk);
    tea_cost_in = t; coffee_cost_in = c; milk_cost_in = m; start = 1'b1;
    cyc = 0; pv_hi = 0; err0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge pclk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == 1) err0 = err;
      if (cyc == poke) begin
        start = 1'b1;
        tea_cost_in = 16'hDEAD; coffee_cost_in = 16'hBEEF; milk_cost_in = 16'hCAFE;
      end
      if (pvalid) pv_hi++;
      if (!busy) break;
    end
    start = 1'b0;
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL run_bound: busy still high after %0d cycles", cyc);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge pclk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Monitor: every transfer start, done pulse and err rise pops one expectation
  initial begin : mon
    logic pv_q, er_q;
    exp_t e, obs;
    pv_q = 1'b0; er_q = 1'b0;
    forever begin
      @(negedge pclk);
      if (pvalid && !pv_q) begin
        obs = '0; obs.kind = K_XFER; obs.wr = wr_rd; obs.addr = paddr; obs.data = pwdata;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_xfer: got %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          check("xfer", obs, e);
        end
      end
      if (done) begin
        obs = '0; obs.kind = K_DONE;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          check("done", obs, e);
        end
      end
      if (err && !er_q) begin
        obs = '0; obs.kind = K_ERR; obs.code = err_code; obs.idx = err_idx;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_err: got %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          check("err", obs, e);
        end
      end
      pv_q = pvalid;
      er_q = err;
    end
  end

  initial begin : stim
    int   cyc, pv_hi;
    logic err0, found;
`ifdef VM_CFG_READBACK_EN
    int   lat_lo = 24, lat_hi = 26;
`else
    int   lat_lo = 12, lat_hi = 14;
`endif
    // Reset values
    repeat (2) @(negedge pclk);
    check("rst_bus", {pvalid, wr_rd, paddr, pwdata}, 64'd0);
    check("rst_status", {busy, done, err, err_code, err_idx}, 64'd0);
    prst = 1'b1;
    repeat (2) @(negedge pclk);

    // Normal programming sequence
    push_seq(16'h0032, 16'h0064, 16'h0019);
    run(16'h0032, 16'h0064, 16'h0019, 0, cyc, pv_hi, err0);
    check_range("done_latency", cyc, lat_lo, lat_hi);
    check("no_err", {err, err_code}, 64'd0);
    check("mem_tea", mem[0], 64'h0032);
    check("mem_coffee", mem[1], 64'h0064);
    check("mem_milk", mem[2], 64'h0019);
    settle();

`ifdef VM_CFG_READBACK_EN
    // Tea readback returns 0x33 instead of 0x32
    mode = 3;
    push_x(1'b1, 16'h0000, 16'h0032);
    push_x(1'b1, 16'h0004, 16'h0064);
    push_x(1'b1, 16'h0008, 16'h0019);
    push_x(1'b0, 16'h0000, 16'h0000);
    push_err(2'b01, 2'd0);
    run(16'h0032, 16'h0064, 16'h0019, 0, cyc, pv_hi, err0);
    repeat (10) @(negedge pclk);
    check("mismatch_status", {err, err_code, err_idx}, {59'd0, 1'b1, 2'b01, 2'd0});
    settle();
    mode = 0;
`endif

    // Slave never answers: pvalid high for exactly TIMEOUT_CYCLES
    mode = 1;
    push_x(1'b1, 16'h0000, 16'h0011);
    push_err(2'b10, 2'd0);
    run(16'h0011, 16'h0022, 16'h0033, 0, cyc, pv_hi, err0);
    check("req_timeout_pvalid_cycles", 64'(pv_hi), 64'd16);
    settle();
    check("sticky_err", {err, err_code, err_idx}, {59'd0, 1'b1, 2'b10, 2'd0});
    mode = 0;
    repeat (2) @(negedge pclk);

    // pready stuck high: first write completes, GAP times out
    mode = 2;
    repeat (2) @(negedge pclk);
    push_x(1'b1, 16'h0000, 16'h0021);
    push_err(2'b10, 2'd0);
    run(16'h0021, 16'h0042, 16'h0063, 0, cyc, pv_hi, err0);
    check("err_cleared_on_start", 64'(err0), 64'd0);
    check("stuck_pvalid_cycles", 64'(pv_hi), 64'd1);
    check_range("gap_timeout_latency", cyc, 18, 18);
    settle();
    mode = 0;
    repeat (3) @(negedge pclk);

    // Asynchronous reset while the third transfer is requesting
    push_seq(16'h0005, 16'h0006, 16'h0007);
    @(negedge pclk);
    tea_cost_in = 16'h0005; coffee_cost_in = 16'h0006; milk_cost_in = 16'h0007; start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pvalid && paddr == 16'h0008) begin
        found = 1'b1;
        break;
      end
      @(posedge pclk); #1;
    end
    check("third_xfer_seen", 64'(found), 64'd1);
    #2 prst = 1'b0;
    #1;
    check("rst_mid_bus", {pvalid, wr_rd, paddr, pwdata}, 64'd0);
    check("rst_mid_status", {busy, done, err, err_code, err_idx}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge pclk);
    prst = 1'b1;
    repeat (4) @(negedge pclk);
    check("idle_after_rst", {busy, done, pvalid}, 64'd0);
    push_seq(16'h0032, 16'h0064, 16'h0019);
    run(16'h0032, 16'h0064, 16'h0019, 0, cyc, pv_hi, err0);
    check_range("rerun_latency", cyc, lat_lo, lat_hi);
    check("rerun_mem", {mem[0], mem[1], mem[2]}, {16'h0, 16'h0032, 16'h0064, 16'h0019});
    settle();

    // Wide tea cost written in full, start while busy ignored
    push_seq(16'h1232, 16'h00A5, 16'h015A);
    run(16'h1232, 16'h00A5, 16'h015A, 5, cyc, pv_hi, err0);
    check_range("wide_latency", cyc, lat_lo, lat_hi);
    check("wide_status", {err, err_code}, 64'd0);
    check("wide_mem", {mem[0], mem[1], mem[2]}, {16'h0, 16'h1232, 16'h00A5, 16'h015A});
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
